// File: rtl/universal_shift_reg_if.sv
// Bundles the operation controls, data and status of universal_shift_reg.
// master drives the controls; slave is the register itself.
interface universal_shift_reg_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 4
);
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_l;
   logic             sin_r;
   logic             start;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, d, sin_l, sin_r, start, amt,
      input  q, sout_l, sout_r, busy, done
   );

   modport slave (
      input  en, mode, d, sin_l, sin_r, start, amt,
      output q, sout_l, sout_r, busy, done
   );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with eight per-cycle operations and a repeat-N engine
// that applies a latched operation N enabled cycles with a busy/done handshake.
module universal_shift_reg #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      AMT_W     = 4
) (
   input logic                 clk,
   input logic                 reset,
   universal_shift_reg_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [AMT_W-1:0] CntOne = AMT_W'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;

   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] ld,
      input logic             sl,
      input logic             sr
   );
      logic [WIDTH-1:0] res;
      res = cur;
      case (op)
         3'b000:  res = cur;
         3'b001:  res = ld;
         3'b010:  res = {cur[WIDTH-2:0], sr};
         3'b011:  res = {sl, cur[WIDTH-1:1]};
         3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
         3'b101:  res = {cur[0], cur[WIDTH-1:1]};
         3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
         default: res = '0;
      endcase
      return res;
   endfunction

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      unique case (state_q)
         StIdle: begin
            // A start request takes precedence and leaves q untouched this edge.
            if (bus.start) begin
               op_d    = bus.mode;
               cnt_d   = bus.amt;
               state_d = (bus.amt != '0) ? StRun : StDone;
            end else if (bus.en) begin
               q_d = apply_op(bus.mode, q_q, bus.d, bus.sin_l, bus.sin_r);
            end
         end
         StRun: begin
            if (bus.en) begin
               q_d   = apply_op(op_q, q_q, bus.d, bus.sin_l, bus.sin_r);
               cnt_d = cnt_q - CntOne;
               if (cnt_q == CntOne) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         q_q     <= RESET_VAL;
         cnt_q   <= '0;
         op_q    <= 3'b000;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign bus.q      = q_q;
   assign bus.sout_l = q_q[WIDTH-1];
   assign bus.sout_r = q_q[0];
   assign bus.busy   = (state_q == StRun);
   assign bus.done   = (state_q == StDone);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: each stimulus cycle pushes the
// expected q/busy/done, which is popped and compared one edge later.
module tb_universal_shift_reg;

   logic clk;
   logic reset;

   universal_shift_reg_if #(.WIDTH(8), .AMT_W(4)) bus ();

   universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .AMT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic [2:0] mode;
      logic [7:0] d;
      logic       sl;
      logic       sr;
      logic       st;
      logic [3:0] amt;
      logic [7:0] eq;
      logic       eb;
      logic       ed;
   } stim_t;

   typedef struct {
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   localparam logic [2:0] MHold = 3'd0, MLoad = 3'd1, MShl = 3'd2, MShr = 3'd3;
   localparam logic [2:0] MRotl = 3'd4, MRotr = 3'd5, MAsr = 3'd6, MClr = 3'd7;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic drive(input stim_t s);
      reset     = s.rst;
      bus.en    = s.en;
      bus.mode  = s.mode;
      bus.d     = s.d;
      bus.sin_l = s.sl;
      bus.sin_r = s.sr;
      bus.start = s.st;
      bus.amt   = s.amt;
      sb.push_back('{q: s.eq, busy: s.eb, done: s.ed});
   endtask

   task automatic test_reset();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b1, 1'b1, MLoad, 8'hxx, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      s.push_back('{1'b1, 1'b1, MLoad, 8'hxx, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h5a, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h5a, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus.q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
            errors++;
            $display("FAIL reset[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_load();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b0, 1'b1, MLoad, 8'ha5, 1'b0, 1'b0, 1'b0, 4'd0, 8'ha5, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b0, MLoad, 8'hff, 1'b0, 1'b0, 1'b0, 4'd0, 8'ha5, 1'b0, 1'b0});
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus.q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
            errors++;
            $display("FAIL load[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
         end
      end
      checks++;
      if (bus.sout_l !== 1'b1 || bus.sout_r !== 1'b1) begin
         errors++;
         $display("FAIL load_sout: got sout_l=%b sout_r=%b, want 1 1", bus.sout_l, bus.sout_r);
      end
   endtask

   task automatic test_direct();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b0, 1'b1, MShl,  8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h4b, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MShr,  8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h25, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MRotr, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h92, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MAsr,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hc9, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MClr,  8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus.q !== e.q || bus.busy !== e.busy || bus.done !== e.done ||
             bus.sout_l !== e.q[7] || bus.sout_r !== e.q[0]) begin
            errors++;
            $display("FAIL direct[%0d]: got q=%h busy=%b done=%b sout=%b%b, want q=%h busy=%b done=%b",
                     i, bus.q, bus.busy, bus.done, bus.sout_l, bus.sout_r, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_repeat();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b0, 1'b1, MLoad, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MRotl, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3, 8'h81, 1'b1, 1'b0});
      // Mode, d, start and amt wiggle during RUN and must be ignored.
      s.push_back('{1'b0, 1'b1, MLoad, 8'hff, 1'b1, 1'b1, 1'b0, 4'd9, 8'h03, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MClr,  8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 8'h06, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MShl,  8'h77, 1'b1, 1'b1, 1'b1, 4'd7, 8'h0c, 1'b0, 1'b1});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h0c, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h0c, 1'b0, 1'b0});
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus.q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
            errors++;
            $display("FAIL repeat[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_stall_abort();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b0, 1'b1, MLoad, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MShl,  8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 8'h01, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h02, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b0, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h02, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b0, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h02, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h04, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h08, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h10, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h20, 1'b0, 1'b1});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h20, 1'b0, 1'b0});
      // Second run, aborted by reset in its third RUN cycle.
      s.push_back('{1'b0, 1'b1, MLoad, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MShl,  8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 8'h01, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h02, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h04, 1'b1, 1'b0});
      s.push_back('{1'b1, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus.q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
            errors++;
            $display("FAIL stall_abort[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_edges();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b0, 1'b1, MLoad, 8'h3c, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3c, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MRotl, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 8'h3c, 1'b0, 1'b1});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3c, 1'b0, 1'b0});
      // Start held through DONE re-triggers in the following IDLE cycle.
      s.push_back('{1'b0, 1'b1, MRotl, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 8'h3c, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MRotl, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 8'h78, 1'b0, 1'b1});
      s.push_back('{1'b0, 1'b1, MRotl, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 8'h78, 1'b0, 1'b0});
      s.push_back('{1'b0, 1'b1, MRotl, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 8'h78, 1'b1, 1'b0});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hf0, 1'b0, 1'b1});
      s.push_back('{1'b0, 1'b1, MHold, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hf0, 1'b0, 1'b0});
      foreach (s[i]) begin
         drive(s[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus.q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
            errors++;
            $display("FAIL edges[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.en    = 1'b0;
      bus.mode  = MHold;
      bus.d     = '0;
      bus.sin_l = 1'b0;
      bus.sin_r = 1'b0;
      bus.start = 1'b0;
      bus.amt   = '0;
      @(negedge clk);
      test_reset();
      test_load();
      test_direct();
      test_repeat();
      test_stall_abort();
      test_edges();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
